// File: rtl/exec_ctrl_pkg.sv
// ============================================================================
// exec_ctrl_pkg : shared state encoding and defaults for the execution control.
// Revision 1.0
// ============================================================================
`default_nettype none

package exec_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STEP = 3'd1,
    S_RUN  = 3'd2,
    S_FAST = 3'd3,
    S_EDIT = 3'd4
  } state_t;

  localparam int unsigned RUN_DIV_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/exec_ctrl_if.sv
// ============================================================================
// exec_ctrl_if : front-panel / CPU / ROM-port bundle of exec_ctrl.
// Optional step_count present when EXEC_CTRL_STEP_CNT_EN is defined.
// Revision 1.0
// ============================================================================
`default_nettype none

interface exec_ctrl_if;
  logic       NEXT;
  logic       RUN;
  logic       SPEEDRUN;
  logic       edit;
  logic       send;
  logic [7:0] unit;
  logic [7:0] code;
  logic       halt;
  logic       step_en;
  logic       rom_we;
  logic [7:0] rom_addr;
  logic [7:0] rom_wdata;
  logic [2:0] mode;
`ifdef EXEC_CTRL_STEP_CNT_EN
  logic [15:0] step_count;

  modport master (
    output NEXT, RUN, SPEEDRUN, edit, send, unit, code, halt,
    input  step_en, rom_we, rom_addr, rom_wdata, mode, step_count
  );
  modport slave (
    input  NEXT, RUN, SPEEDRUN, edit, send, unit, code, halt,
    output step_en, rom_we, rom_addr, rom_wdata, mode, step_count
  );
`else
  modport master (
    output NEXT, RUN, SPEEDRUN, edit, send, unit, code, halt,
    input  step_en, rom_we, rom_addr, rom_wdata, mode
  );
  modport slave (
    input  NEXT, RUN, SPEEDRUN, edit, send, unit, code, halt,
    output step_en, rom_we, rom_addr, rom_wdata, mode
  );
`endif
endinterface

`default_nettype wire

// File: rtl/exec_ctrl_edge_det.sv
// ============================================================================
// edge_det : 1-bit rising-edge detector, async active-low reset.
// Revision 1.0
// ============================================================================
`default_nettype none

module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev;
  logic armed;

  // armed stays low for the first clock after reset so a level already high
  // at release is absorbed into the history instead of reading as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= din;
      armed <= 1'b1;
    end
  end

  assign rise = din & ~prev & armed;

endmodule

`default_nettype wire

// File: rtl/exec_ctrl.sv
// ============================================================================
// exec_ctrl : step / run / full-speed / ROM-edit controller for a small CPU.
// Optional macro EXEC_CTRL_STEP_CNT_EN adds a saturating step_count output.
// Revision 1.0
// ============================================================================
`default_nettype none

module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned RUN_DIV = RUN_DIV_DEFAULT  // legal 1..255
) (
  input  logic        clk,
  input  logic        rst,
  exec_ctrl_if.slave  bus
);

  localparam logic [7:0] DIV_LAST = 8'(RUN_DIV - 1);

  logic       next_rise;
  logic       speed_rise;
  logic       send_rise;
  state_t     state;
  logic       step_q;
  logic       rom_we_q;
  logic       wr_pend;
  logic       run_blocked;
  logic [7:0] div;
  logic [7:0] rom_addr_q;
  logic [7:0] rom_wdata_q;
  logic       step_out;

  edge_det u_next_det  (.clk(clk), .rst(rst), .din(bus.NEXT),     .rise(next_rise));
  edge_det u_speed_det (.clk(clk), .rst(rst), .din(bus.SPEEDRUN), .rise(speed_rise));
  edge_det u_send_det  (.clk(clk), .rst(rst), .din(bus.send),     .rise(send_rise));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      step_q      <= 1'b0;
      rom_we_q    <= 1'b0;
      wr_pend     <= 1'b0;
      run_blocked <= 1'b0;
      div         <= 8'd0;
      rom_addr_q  <= 8'd0;
      rom_wdata_q <= 8'd0;
    end else begin
      step_q   <= 1'b0;
      rom_we_q <= 1'b0;
      wr_pend  <= 1'b0;
      if (!bus.RUN)
        run_blocked <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.edit)
            state <= S_EDIT;
          else if (speed_rise)
            state <= S_FAST;
          else if (bus.RUN && !run_blocked) begin
            state <= S_RUN;
            div   <= 8'd0;
          end else if (next_rise)
            state <= S_STEP;
        end

        S_STEP: begin
          step_q <= ~bus.halt;
          state  <= S_IDLE;
        end

        S_RUN: begin
          if (!bus.RUN || bus.edit || bus.halt) begin
            state <= S_IDLE;
            if (bus.halt && bus.RUN)
              run_blocked <= 1'b1;
          end else begin
            step_q <= (div == 8'd0);
            div    <= (div == DIV_LAST) ? 8'd0 : div + 8'd1;
          end
        end

        // A held RUN must not restart paced execution after a halt ends FAST.
        S_FAST: begin
          if (bus.halt || bus.edit) begin
            state <= S_IDLE;
            if (bus.halt && bus.RUN)
              run_blocked <= 1'b1;
          end else
            step_q <= 1'b1;
        end

        S_EDIT: begin
          if (!bus.edit)
            state <= S_IDLE;
          else begin
            rom_we_q <= wr_pend;
            if (send_rise) begin
              rom_addr_q  <= bus.unit;
              rom_wdata_q <= bus.code;
              wr_pend     <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Gating with the live halt level keeps step_en low even if halt rises mid-cycle.
  assign step_out      = step_q & ~bus.halt;
  assign bus.step_en   = step_out;
  assign bus.rom_we    = rom_we_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign bus.mode      = state;

`ifdef EXEC_CTRL_STEP_CNT_EN
  logic [15:0] step_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      step_cnt <= 16'd0;
    else if (state == S_IDLE && bus.edit)
      step_cnt <= 16'd0;
    else if (step_out && step_cnt != 16'hFFFF)
      step_cnt <= step_cnt + 16'd1;
  end

  assign bus.step_count = step_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter RUN_DIV, default 4, meaning clock cycles per step in RUN mode (legal 1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port NEXT  input  1  single-step request, synchronous to clk, rising edge acts.
REQ-005 SHALL have port RUN  input  1  level; continuous paced execution while high.
REQ-006 SHALL have port SPEEDRUN  input  1  rising edge starts full-speed execution.
REQ-007 SHALL have port edit  input  1  level; ROM programming mode request.
REQ-008 SHALL have port send  input  1  rising edge commits one ROM word in edit mode.
REQ-009 SHALL have port unit  input  8  ROM address for programming.
REQ-010 SHALL have port code  input  8  ROM data for programming.
REQ-011 SHALL have port halt  input  1  CPU halt indication, level.
REQ-012 SHALL have port step_en  output  1  one-cycle CPU advance enable.
REQ-013 SHALL have port rom_we  output  1  one-cycle ROM write strobe.
REQ-014 SHALL have port rom_addr  output  8  registered ROM write address.
REQ-015 SHALL have port rom_wdata  output  8  registered ROM write data.
REQ-016 SHALL have port mode  output  3  current state encoding from the package.

Function
REQ-017 SHALL implement states IDLE, STEP, RUN, FAST, EDIT.
REQ-018 Edge detect: input sampled high at edge k and low at edge k-1 is a rising edge at k; SHALL use no synchronizer.
REQ-019 IDLE exit priority, evaluated at edge k: edit -> EDIT; SPEEDRUN edge -> FAST; RUN high and not run_blocked -> RUN; NEXT edge -> STEP; else stay.
REQ-020 STEP SHALL drive step_en high for exactly one cycle (edge k+1 to k+2), then return to IDLE.
REQ-021 RUN SHALL pulse step_en once every RUN_DIV cycles, first pulse one cycle after entry; divider counter SHALL wrap RUN_DIV-1 -> 0.
REQ-022 RUN SHALL return to IDLE when RUN low, edit high, or halt high, with no further step_en.
REQ-023 FAST SHALL hold step_en high every cycle until halt or edit high, then go to IDLE; RUN level SHALL NOT stop FAST.
REQ-024 halt in RUN SHALL set run_blocked; run_blocked SHALL clear only when RUN samples low.
REQ-025 step_en SHALL never assert while halt is high, in any state.
REQ-026 EDIT SHALL keep step_en low; send edge at k SHALL capture unit/code into rom_addr/rom_wdata and assert rom_we for one cycle (edge k+1 to k+2).
REQ-027 EDIT SHALL return to IDLE when edit samples low; a send edge coincident with edit falling SHALL be ignored.
REQ-028 rom_we SHALL assert only in EDIT; NEXT/RUN/SPEEDRUN edges in EDIT SHALL be discarded, not queued.
REQ-029 Held-high NEXT or SPEEDRUN SHALL act once per rising edge only.

Reset
REQ-030 rst low SHALL force IDLE, step_en=0, rom_we=0, rom_addr=0, rom_wdata=0, run_blocked=0, divider=0, edge history=0, immediately and asynchronously.
REQ-031 Inputs held high through reset release SHALL NOT produce an edge on the first clock after release.
REQ-032 Reset mid-FAST or mid-write SHALL drop step_en/rom_we within the same cycle.

Configuration
REQ-033 With EXEC_CTRL_STEP_CNT_EN defined, SHALL add output step_count (16 bits): +1 per step_en cycle, saturating at 0xFFFF, reset 0, cleared on entry to EDIT.
REQ-034 Without EXEC_CTRL_STEP_CNT_EN, step_count port and its logic SHALL be absent.

Structure
REQ-035 Package exec_ctrl_pkg SHALL hold the state enum (IDLE=0, STEP=1, RUN=2, FAST=3, EDIT=4) and the RUN_DIV default constant.
REQ-036 Sub-module edge_det (1-bit registered rising-edge detector, async active-low reset) SHALL be instantiated for NEXT, SPEEDRUN, send.

Verification
REQ-037 NEXT pulse 3 cycles from IDLE -> exactly one step_en cycle, mode back to 0.
REQ-038 RUN high 20 cycles, RUN_DIV=4 -> 5 step_en pulses spaced 4 cycles; RUN low -> IDLE.
REQ-039 edit=1, unit=1 code=0x10 send, unit=2 code=0x30 send -> two rom_we pulses with addr/data 1/0x10, 2/0x30; step_en stays 0.
REQ-040 SPEEDRUN edge then halt after 10 cycles -> step_en high exactly 10 cycles, IDLE; RUN held high stays blocked until dropped.
REQ-041 rst low mid-FAST with NEXT held high -> all outputs 0 instantly; no step_en after release until new NEXT edge.
REQ-042 With EXEC_CTRL_STEP_CNT_EN, 3 NEXT edges -> step_count=3; entering EDIT -> 0.
